// File: rtl/fft_frame_ctrl_pkg.sv
// Shared constants, state encoding and lane index helper for the FFT frame sequencer.
package fft_ctrl_pkg;

  localparam int unsigned LANES      = 4;
  localparam int unsigned LANE_DEPTH = 4;
  localparam int unsigned FRAME      = 16;
  localparam int unsigned PTR_W      = 3;
  localparam int unsigned IDX_W      = 4;
  localparam int unsigned ERR_W      = 3;

  localparam int unsigned ERR_FRAME   = 0;
  localparam int unsigned ERR_LANE    = 1;
  localparam int unsigned ERR_TIMEOUT = 2;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } ctrl_state_t;

  // Buffer index served by a lane; the pointer saturates on the lane's last slot.
  function automatic logic [IDX_W-1:0] laneIndex(input int unsigned lane,
                                                 input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] sat;
    sat = (ptr >= PTR_W'(LANE_DEPTH)) ? PTR_W'(LANE_DEPTH - 1) : ptr;
    return IDX_W'(lane * LANE_DEPTH) + IDX_W'(sat);
  endfunction

endpackage

// File: rtl/fft_frame_ctrl_if.sv
// Sample stream, result stream and fft_wrap lane/handshake bundle.
interface fft_frame_ctrl_if #(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned OUT_W = 42
);
  import fft_ctrl_pkg::*;

  logic [IN_W-1:0]        s_data;
  logic                   s_valid;
  logic                   s_last;
  logic                   s_ready;

  logic [OUT_W-1:0]       m_data;
  logic                   m_valid;
  logic                   m_last;
  logic                   m_ready;

  logic                   core_start;
  logic                   core_ready;
  logic                   core_done;
  logic                   core_idle;

  logic [LANES-1:0]       in_ce;
  logic [LANES*IN_W-1:0]  in_data;
  logic [LANES-1:0]       out_we;
  logic [LANES*OUT_W-1:0] out_data;

  // Controller side
  modport master (
    input  s_data, s_valid, s_last, m_ready,
    input  core_ready, core_done, core_idle, in_ce, out_we, out_data,
    output s_ready, m_data, m_valid, m_last, core_start, in_data
  );

  // Source, sink and core side
  modport slave (
    output s_data, s_valid, s_last, m_ready,
    output core_ready, core_done, core_idle, in_ce, out_we, out_data,
    input  s_ready, m_data, m_valid, m_last, core_start, in_data
  );

endinterface

// File: rtl/fft_lane_ptr.sv
// Saturating per-lane slot pointer; flags a strobe that arrives after the lane is exhausted.
module fft_lane_ptr
  import fft_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr,
  output logic             overrunC
);

  assign overrunC = inc && (ptr == PTR_W'(LANE_DEPTH));

  // Pointer advances per strobe and holds once all slots are used
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ptr <= '0;
    end else if (inc && !overrunC) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer: buffers a 16-sample frame, runs fft_wrap over its lanes, streams results.
module fft_frame_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int unsigned IN_W    = 32,
  parameter int unsigned OUT_W   = 42,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  fft_frame_ctrl_if.master  bus,
  input  logic              clr_err,
  output logic [ERR_W-1:0]  err,
  output logic [15:0]       frame_cnt
);

  localparam int unsigned TCNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  ctrl_state_t state, stateNext;

  logic [IN_W-1:0]  ibuf [FRAME];
  logic [OUT_W-1:0] obuf [FRAME];

  logic [IDX_W-1:0]  wptr, wptrNext;
  logic [IDX_W-1:0]  rptr, rptrNext;
  logic [TCNT_W-1:0] tcnt, tcntNext;
  logic [ERR_W-1:0]  errQ, errSet;
  logic [15:0]       frameCnt;
  logic              frameInc;
  logic              lanesClr;

  logic sReadyQ, coreStartQ, mValidQ, mLastQ;
  logic inHs, outHs;

  logic [PTR_W-1:0]      inPtr  [LANES];
  logic [PTR_W-1:0]      outPtr [LANES];
  logic [LANES-1:0]      inOvr, outOvr, outFull;
  logic [LANES*IN_W-1:0] inDataC;

  assign inHs  = bus.s_valid && sReadyQ;
  assign outHs = mValidQ && bus.m_ready;

  // Four input-lane and four output-lane pointers, plus the combinational lane read mux
  for (genvar k = 0; k < LANES; k++) begin : gLane
    fft_lane_ptr uInPtr (
      .clk      (clk),
      .rst      (rst),
      .clr      (lanesClr),
      .inc      (bus.in_ce[k]),
      .ptr      (inPtr[k]),
      .overrunC (inOvr[k])
    );
    fft_lane_ptr uOutPtr (
      .clk      (clk),
      .rst      (rst),
      .clr      (lanesClr),
      .inc      (bus.out_we[k]),
      .ptr      (outPtr[k]),
      .overrunC (outOvr[k])
    );
    assign outFull[k] = (outPtr[k] == PTR_W'(LANE_DEPTH));
    assign inDataC[k*IN_W +: IN_W] = ibuf[laneIndex(k, inPtr[k])];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= stateNext;
    end
  end

  // Next state, pointer updates and error events
  always_comb begin
    stateNext = state;
    wptrNext  = wptr;
    rptrNext  = rptr;
    tcntNext  = tcnt;
    errSet    = '0;
    lanesClr  = 1'b0;
    frameInc  = 1'b0;
    errSet[ERR_LANE] = (|inOvr) | (|outOvr);
    case (state)
      LOAD: begin
        if (inHs) begin
          if (wptr == IDX_W'(FRAME - 1)) begin
            wptrNext = '0;
            if (bus.s_last) begin
              stateNext = START;
              lanesClr  = 1'b1;
              tcntNext  = '0;
            end else begin
              errSet[ERR_FRAME] = 1'b1;
            end
          end else if (bus.s_last) begin
            errSet[ERR_FRAME] = 1'b1;
            wptrNext = '0;
          end else begin
            wptrNext = wptr + 1'b1;
          end
        end
      end
      START, WAIT: begin
        if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
          errSet[ERR_TIMEOUT] = 1'b1;
          stateNext = LOAD;
        end else begin
          tcntNext = tcnt + 1'b1;
          if (state == START) begin
            if (bus.core_ready) begin
              stateNext = bus.core_done ? DRAIN : WAIT;
            end
          end else if (bus.core_done) begin
            stateNext = DRAIN;
          end
          if (stateNext == DRAIN) begin
            rptrNext = '0;
            if (!(&outFull)) begin
              errSet[ERR_LANE] = 1'b1;
            end
          end
        end
      end
      DRAIN: begin
        if (outHs) begin
          if (rptr == IDX_W'(FRAME - 1)) begin
            stateNext = LOAD;
            rptrNext  = '0;
            frameInc  = 1'b1;
          end else begin
            rptrNext = rptr + 1'b1;
          end
        end
      end
      default: stateNext = LOAD;
    endcase
  end

  // Counters, sticky errors and registered stream/handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      tcnt       <= '0;
      errQ       <= '0;
      frameCnt   <= '0;
      sReadyQ    <= 1'b0;
      coreStartQ <= 1'b0;
      mValidQ    <= 1'b0;
      mLastQ     <= 1'b0;
    end else begin
      wptr       <= wptrNext;
      rptr       <= rptrNext;
      tcnt       <= tcntNext;
      errQ       <= (clr_err ? '0 : errQ) | errSet;
      frameCnt   <= frameCnt + 16'(frameInc);
      sReadyQ    <= (stateNext == LOAD);
      coreStartQ <= (stateNext == START);
      mValidQ    <= (stateNext == DRAIN);
      mLastQ     <= (stateNext == DRAIN) && (rptrNext == IDX_W'(FRAME - 1));
    end
  end

  // Input frame capture
  always_ff @(posedge clk) begin
    if (inHs) begin
      ibuf[wptr] <= bus.s_data;
    end
  end

  // Result capture from the core's output lanes; writes past a lane's fourth slot are dropped
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < LANES; k++) begin
      if (bus.out_we[k] && !outOvr[k]) begin
        obuf[laneIndex(k, outPtr[k])] <= bus.out_data[k*OUT_W +: OUT_W];
      end
    end
  end

  assign bus.s_ready    = sReadyQ;
  assign bus.core_start = coreStartQ;
  assign bus.m_valid    = mValidQ;
  assign bus.m_last     = mLastQ;
  assign bus.m_data     = obuf[rptr];
  assign bus.in_data    = inDataC;
  assign err            = errQ;
  assign frame_cnt      = frameCnt;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl with a behavioural fft_wrap lane model.
module tb_fft_frame_ctrl;

  localparam int unsigned IN_W    = 32;
  localparam int unsigned OUT_W   = 42;
  localparam int unsigned TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_err;
  logic [2:0]  err;
  logic [15:0] frame_cnt;

  fft_frame_ctrl_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  fft_frame_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .clr_err   (clr_err),
    .err       (err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sBase;
    logic [41:0] rBase;
    bit          mToggle;
    logic [15:0] gaps;
    logic [41:0] expFirst;
    logic [41:0] expLast;
    logic [15:0] expCnt;
    logic [2:0]  expErr;
  } frame_vec_t;

  int          nChecks = 0;
  int          nFail   = 0;
  bit          hang    = 1'b0;
  bit          ovrMode = 1'b0;
  logic [41:0] curRBase = '0;
  logic [31:0] expSample [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Core model: accept start, read each lane four times, write four results per lane, pulse done
  initial begin : coreModel
    bus.core_ready = 1'b0;
    bus.core_done  = 1'b0;
    bus.core_idle  = 1'b1;
    bus.in_ce      = '0;
    bus.out_we     = '0;
    bus.out_data   = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.core_start === 1'b1) begin
        bus.core_ready = 1'b1;
        bus.core_idle  = 1'b0;
        @(posedge clk); #1;
        bus.core_ready = 1'b0;
        check("core_start drop after ready", 64'(bus.core_start), 64'(0));
        if (!hang) begin
          for (int j = 0; j < 4; j++) begin
            bus.in_ce = 4'hF;
            for (int k = 0; k < 4; k++)
              check("in_data lane read", 64'(bus.in_data[k*IN_W +: IN_W]), 64'(expSample[4*k + j]));
            @(posedge clk); #1;
          end
          if (ovrMode) begin
            bus.in_ce = 4'b0100;
            check("lane2 fifth read", 64'(bus.in_data[2*IN_W +: IN_W]), 64'(expSample[11]));
            @(posedge clk); #1;
          end
          bus.in_ce = '0;
          for (int j = 0; j < 4; j++) begin
            bus.out_we = 4'hF;
            for (int k = 0; k < 4; k++)
              bus.out_data[k*OUT_W +: OUT_W] = curRBase + 42'(4*k + j);
            @(posedge clk); #1;
          end
          bus.out_we    = '0;
          bus.core_done = 1'b1;
          @(posedge clk); #1;
          bus.core_done = 1'b0;
          bus.core_idle = 1'b1;
          check("m_valid after done", 64'(bus.m_valid), 64'(1));
        end else begin
          bus.core_idle = 1'b1;
        end
      end
    end
  end

  task automatic sendSamples(input logic [31:0] base, input int n, input int lastAt,
                             input logic [15:0] gaps);
    int t;
    for (int i = 0; i < n; i++) begin
      if (gaps[i[3:0]]) begin
        bus.s_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.s_valid = 1'b1;
      bus.s_data  = base + 32'(i);
      bus.s_last  = (i == lastAt);
      t = 0;
      while (bus.s_ready !== 1'b1 && t < 200) begin
        @(posedge clk); #1;
        t++;
      end
      if (t >= 200) check("s_ready wait budget", 64'(bus.s_ready), 64'(1));
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic drainFrame(input logic [41:0] rBase, input bit toggle,
                            input logic [41:0] expFirst, input logic [41:0] expLast);
    int got = 0;
    int t   = 0;
    bit ph  = 1'b0;
    logic [41:0] held;
    while (got < 16 && t < 400) begin
      bus.m_ready = toggle ? ph : 1'b1;
      ph = ~ph;
      if (bus.m_valid === 1'b1 && bus.m_ready) begin
        check("m_data order", 64'(bus.m_data), 64'(rBase + 42'(got)));
        check("m_last", 64'(bus.m_last), 64'(got == 15));
        if (got == 0)  check("first word", 64'(bus.m_data), 64'(expFirst));
        if (got == 15) check("last word", 64'(bus.m_data), 64'(expLast));
        got++;
        @(posedge clk); #1;
      end else if (bus.m_valid === 1'b1) begin
        held = bus.m_data;
        @(posedge clk); #1;
        check("stall hold", {22'(bus.m_valid), 42'(bus.m_data)}, {22'(1), held});
      end else begin
        @(posedge clk); #1;
      end
      t++;
    end
    check("drain word count", 64'(got), 64'(16));
    bus.m_ready = 1'b0;
    check("s_ready after drain", 64'(bus.s_ready), 64'(1));
    check("m_valid after drain", 64'(bus.m_valid), 64'(0));
  endtask

  task automatic runGoodFrame(input frame_vec_t v);
    curRBase = v.rBase;
    for (int i = 0; i < 16; i++) expSample[i] = v.sBase + 32'(i);
    sendSamples(v.sBase, 16, 15, v.gaps);
    check("core_start after last sample", 64'(bus.core_start), 64'(1));
    drainFrame(v.rBase, v.mToggle, v.expFirst, v.expLast);
    check("frame_cnt", 64'(frame_cnt), 64'(v.expCnt));
    check("err after frame", 64'(err), 64'(v.expErr));
  endtask

  task automatic pulseClr();
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    check("err cleared", 64'(err), 64'(0));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    frame_vec_t vecs [3];
    frame_vec_t v;
    int n;
    vecs[0] = '{32'h0000_0000, 42'h100,         1'b0, 16'h0000, 42'h100,         42'h10F,         16'd1, 3'b000};
    vecs[1] = '{32'hA5A5_0000, 42'h2AA_AAAA_AA00, 1'b1, 16'h0421, 42'h2AA_AAAA_AA00, 42'h2AA_AAAA_AA0F, 16'd2, 3'b000};
    vecs[2] = '{32'hFFFF_FFF0, 42'h3FF_FFFF_FFF0, 1'b1, 16'hFFFF, 42'h3FF_FFFF_FFF0, 42'h3FF_FFFF_FFFF, 16'd3, 3'b000};

    rst = 1'b1;
    clr_err = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset s_ready", 64'(bus.s_ready), 64'(0));
    check("reset m_valid", 64'(bus.m_valid), 64'(0));
    check("reset m_last", 64'(bus.m_last), 64'(0));
    check("reset core_start", 64'(bus.core_start), 64'(0));
    check("reset err", 64'(err), 64'(0));
    check("reset frame_cnt", 64'(frame_cnt), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    check("s_ready after release", 64'(bus.s_ready), 64'(1));

    // Nominal and backpressured frames
    for (int i = 0; i < 3; i++) runGoodFrame(vecs[i]);

    // Early s_last on sample 10: frame discarded, core never started
    sendSamples(32'h0000_0500, 11, 10, 16'h0000);
    check("framing err early last", 64'(err), 64'(3'b001));
    check("no start after bad frame", 64'(bus.core_start), 64'(0));
    check("s_ready after bad frame", 64'(bus.s_ready), 64'(1));
    pulseClr();

    // Missing s_last on the 16th sample, with clr_err in the same cycle: error wins
    sendSamples(32'h0000_0600, 15, -1, 16'h0000);
    bus.s_valid = 1'b1;
    bus.s_data  = 32'h0000_060F;
    bus.s_last  = 1'b0;
    clr_err     = 1'b1;
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    clr_err     = 1'b0;
    check("framing err beats clear", 64'(err), 64'(3'b001));
    check("no start after missing last", 64'(bus.core_start), 64'(0));

    v = '{32'h0000_0700, 42'h050, 1'b0, 16'h0000, 42'h050, 42'h05F, 16'd4, 3'b001};
    runGoodFrame(v);
    pulseClr();

    // Fifth read on lane 2
    ovrMode = 1'b1;
    v = '{32'h1234_0000, 42'h0AB_0000_0000, 1'b0, 16'h0000, 42'h0AB_0000_0000, 42'h0AB_0000_000F, 16'd5, 3'b010};
    runGoodFrame(v);
    ovrMode = 1'b0;
    pulseClr();

    // Core never signals done
    hang = 1'b1;
    curRBase = '0;
    for (int i = 0; i < 16; i++) expSample[i] = 32'h0000_0900 + 32'(i);
    sendSamples(32'h0000_0900, 16, 15, 16'h0000);
    check("core_start before timeout", 64'(bus.core_start), 64'(1));
    n = 0;
    while (err[2] !== 1'b1 && n < int'(TIMEOUT) + 8) begin
      check("no m_valid before timeout", 64'(bus.m_valid), 64'(0));
      @(posedge clk); #1;
      n++;
    end
    check("timeout window", 64'(n >= 32 && n <= int'(TIMEOUT)), 64'(1));
    check("timeout err", 64'(err), 64'(3'b100));
    check("core_start after timeout", 64'(bus.core_start), 64'(0));
    check("s_ready after timeout", 64'(bus.s_ready), 64'(1));
    check("frame_cnt after timeout", 64'(frame_cnt), 64'(5));
    hang = 1'b0;

    // Reset while rptr=7
    curRBase = 42'h0CC_0000_0000;
    for (int i = 0; i < 16; i++) expSample[i] = 32'h0000_0A00 + 32'(i);
    sendSamples(32'h0000_0A00, 16, 15, 16'h0000);
    bus.m_ready = 1'b1;
    n = 0;
    while (bus.m_valid !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("m_valid before mid-drain reset", 64'(bus.m_valid), 64'(1));
    repeat (7) begin
      @(posedge clk); #1;
    end
    check("m_data at rptr 7", 64'(bus.m_data), 64'(42'h0CC_0000_0007));
    bus.m_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("m_valid after mid-drain reset", 64'(bus.m_valid), 64'(0));
    check("frame_cnt after reset", 64'(frame_cnt), 64'(0));
    check("err after reset", 64'(err), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    check("s_ready after reset release", 64'(bus.s_ready), 64'(1));

    v = '{32'h0000_0B00, 42'h200, 1'b1, 16'h8001, 42'h200, 42'h20F, 16'd1, 3'b000};
    runGoodFrame(v);

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
